data_mem_resp: RTL and testbench
================================

Name: data_mem_resp

Overview:
- Data-memory responder: the memory side of the CPU's data port (memCe/memWr/memAddr/wtData in, rdData out).
- Word-organised RAM with a single write port, shared by two writers:
  - a posted CPU store buffer (FIFO);
  - a preload port used by benches and boot logic.
- Loads return combinationally in the same cycle, with forwarding from pending stores, so CPU timing is unchanged.

Parameters:
- DEPTH_LOG2, 10, log2 of RAM depth in 32-bit words (1024 words).
- WBUF_DEPTH, 4, store-buffer entries; power of 2, ≥2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- memCe  in  1  data access enable from CPU.
- memWr  in  1  1 = store, 0 = load; valid when memCe=1.
- memAddr  in  32  byte address; word index = memAddr[DEPTH_LOG2+1:2]; upper bits ignored (aliasing).
- wtData  in  32  store data.
- rdData  out  32  load data, combinational.
- ldValid  in  1  preload write request.
- ldReady  out  1  preload accepted this cycle when ldValid=1.
- ldAddr  in  DEPTH_LOG2  preload word index.
- ldData  in  32  preload data.
- wbufCnt  out  log2(WBUF_DEPTH)+1  store-buffer occupancy.
- alignErr  out  1  sticky: a misaligned access was seen.

Behaviour:
- Reset (rst=0, async):
  - FIFO pointers and count = 0; alignErr = 0.
  - RAM contents are not reset.
  - During reset: rdData=0, ldReady=0.
- Alignment:
  - An access is misaligned when memCe=1 and memAddr[1:0]≠0.
  - Misaligned store: dropped, no enqueue.
  - Misaligned load: rdData=0.
  - Either case sets alignErr on the next edge; alignErr clears only on reset.
- Store path: an aligned store enqueues {word index, wtData} at the tail on the rising edge. CPU never stalls (latency 1 cycle to buffer).
- Write-port arbitration (one RAM write per cycle):
  - Priority 1, preload: ldValid && ldReady writes ldData to RAM[ldAddr]; no drain this cycle.
  - Priority 2, drain: otherwise, if count>0, the head entry is written to RAM and popped.
  - ldReady = (count < WBUF_DEPTH-1). Once count reaches WBUF_DEPTH-1 the preload is blocked, drain runs, and any simultaneous store leaves count unchanged.
- FIFO invariant: count ≤ WBUF_DEPTH-1. The full state is unreachable; assert on violation.
- Simultaneous enqueue + pop: count unchanged; pointers wrap modulo WBUF_DEPTH.
- Load path (memCe=1, memWr=0, aligned):
  - rdData = data of the newest FIFO entry whose index matches, else RAM[index].
  - Forwarding includes the head entry being drained this cycle.
  - memCe=0 or a store: rdData = 0.
- Ordering:
  - Loader writes are ordered older than any CPU store already buffered, so a pending store to the same word later overwrites the preload.
  - Loader starvation while stores are buffered is acceptable; only drain progress is guaranteed.
- Reset mid-operation: pending FIFO entries are discarded, not written.

Optional Feature:
- Macro: DMEM_STATS_EN.
- Defined:
  - Adds 32-bit wrapping counters, reset to 0: storeCnt (accepted stores), loadFwdCnt (loads served from FIFO), ldStallCnt (cycles with ldValid=1 && ldReady=0).
  - Each counter is exported as an output port.
- Undefined: ports and logic absent; all other behaviour identical.

Decomposition:
- Shared package (define file):
  - word-index width derived from DEPTH_LOG2;
  - store-buffer entry struct/width {index, data};
  - rdData-zero constant.
- One natural sub-module, dmem_store_fifo:
  - pointers, count, push/pop, wrap;
  - parallel newest-match lookup for forwarding.
- Top level holds the RAM array, arbitration, alignment check and counters.

Test Plan:
- Store then load: store 0x0000_0010 ← 0xDEAD_BEEF, load the same address next cycle → rdData=0xDEAD_BEEF. Check it is forwarded while wbufCnt=1, and read from RAM after drain (wbufCnt=0).
- Newest-match forwarding: ldValid held 1 to block drain, stores 0x20←1 then 0x20←2 → load 0x20 returns 2. Then drop ldValid → after drain, RAM[8]=2.
- Backpressure, WBUF_DEPTH=4: continuous ldValid plus one store per cycle → ldReady falls when wbufCnt=3; wbufCnt never exceeds 3; all stores land in order.
- Misaligned access: store to 0x0000_0013 → no enqueue, wbufCnt stays 0, alignErr=1 next cycle and stays 1. Load from 0x0000_0002 → rdData=0.
- Aliasing and ordering: preload RAM[5]=0xAAAA with a store to 0x0000_1014 (index 5, DEPTH_LOG2=10) pending → final RAM[5] = store data.
- Async reset: assert rst=0 mid-cycle with 2 entries pending → wbufCnt=0 immediately, entries never written; RAM retains prior values. With DMEM_STATS_EN, counters read 0.

Source files
------------

// File: rtl/data_mem_resp_pkg.sv
// Shared widths and constants for the data-memory responder and its store buffer.
package data_mem_resp_pkg;

  localparam int unsigned DATA_W         = 32;
  localparam int unsigned DEPTH_LOG2_DEF = 10;
  localparam int unsigned WBUF_DEPTH_DEF = 4;

  localparam logic [DATA_W-1:0] RD_ZERO = '0;

  // Default store-buffer entry layout: {word index, data}.
  typedef struct packed {
    logic [DEPTH_LOG2_DEF-1:0] idx;
    logic [DATA_W-1:0]         data;
  } wbufEntry_t;

  // Packed {index, data} entry width for a given word-index width.
  function automatic int unsigned entryW(input int unsigned idxW);
    return idxW + DATA_W;
  endfunction

endpackage

// File: rtl/dmem_store_fifo.sv
// Posted store buffer: circular FIFO of {word index, data} with a newest-match
// lookup across all live entries for load forwarding.
module dmem_store_fifo
  import data_mem_resp_pkg::*;
#(
  parameter int unsigned IDX_W = DEPTH_LOG2_DEF,
  parameter int unsigned DEPTH = WBUF_DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [IDX_W-1:0]         pushIdx,
  input  logic [DATA_W-1:0]        pushData,
  input  logic                     pop,
  output logic [IDX_W-1:0]         headIdx,
  output logic [DATA_W-1:0]        headData,
  output logic [$clog2(DEPTH):0]   count,
  input  logic [IDX_W-1:0]         lookupIdx,
  output logic                     hit,
  output logic [DATA_W-1:0]        hitData
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned ENTRY_W = entryW(IDX_W);

  logic [ENTRY_W-1:0] entries [DEPTH];
  logic [PTR_W-1:0]   rdPtr;
  logic [PTR_W-1:0]   wrPtr;

  always_ff @(posedge clk) begin
    if (push) entries[wrPtr] <= {pushIdx, pushData};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + PTR_W'(1);
      if (pop)  rdPtr <= rdPtr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  assign headIdx  = entries[rdPtr][ENTRY_W-1:DATA_W];
  assign headData = entries[rdPtr][DATA_W-1:0];

  // Walk oldest to newest so the youngest matching entry wins.
  always_comb begin
    logic [PTR_W-1:0] slot;
    hit     = 1'b0;
    hitData = RD_ZERO;
    slot    = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      slot = rdPtr + PTR_W'(i);
      if ((CNT_W'(i) < count) && (entries[slot][ENTRY_W-1:DATA_W] == lookupIdx)) begin
        hit     = 1'b1;
        hitData = entries[slot][DATA_W-1:0];
      end
    end
  end

  // The full state must never be reached; arbitration always drains at DEPTH-1.
  assert property (@(posedge clk) disable iff (!rst) (count < CNT_W'(DEPTH)));

endmodule

// File: rtl/data_mem_resp.sv
// Data-memory responder: word RAM behind a posted store buffer plus a preload port.
// Optional DMEM_STATS_EN adds store / forwarded-load / preload-stall counters.
module data_mem_resp
  import data_mem_resp_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEF,
  parameter int unsigned WBUF_DEPTH = WBUF_DEPTH_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         memCe,
  input  logic                         memWr,
  input  logic [31:0]                  memAddr,
  input  logic [31:0]                  wtData,
  output logic [31:0]                  rdData,
  input  logic                         ldValid,
  output logic                         ldReady,
  input  logic [DEPTH_LOG2-1:0]        ldAddr,
  input  logic [31:0]                  ldData,
  output logic [$clog2(WBUF_DEPTH):0]  wbufCnt,
  output logic                         alignErr
`ifdef DMEM_STATS_EN
  ,
  output logic [31:0]                  storeCnt,
  output logic [31:0]                  loadFwdCnt,
  output logic [31:0]                  ldStallCnt
`endif
);

  localparam int unsigned CNT_W     = $clog2(WBUF_DEPTH) + 1;
  localparam int unsigned RAM_WORDS = 1 << DEPTH_LOG2;

  logic [31:0]           ram [RAM_WORDS];
  logic [DEPTH_LOG2-1:0] wordIdx;
  logic [DEPTH_LOG2-1:0] headIdx;
  logic [31:0]           headData;
  logic [31:0]           fwdData;
  logic                  fwdHit;
  logic                  misaligned;
  logic                  storeAcc;
  logic                  loadAcc;
  logic                  preloadWr;
  logic                  drain;
  logic                  unusedAddrBits;

  // Upper address bits alias onto the RAM.
  assign unusedAddrBits = ^memAddr[31:DEPTH_LOG2+2];

  assign wordIdx    = memAddr[DEPTH_LOG2+1:2];
  assign misaligned = memCe && (memAddr[1:0] != 2'b00);
  assign storeAcc   = memCe && memWr && !misaligned;
  assign loadAcc    = memCe && !memWr && !misaligned;

  // Preload wins the single write port unless the buffer is one short of full.
  assign ldReady   = rst && (wbufCnt < CNT_W'(WBUF_DEPTH - 1));
  assign preloadWr = ldValid && ldReady;
  assign drain     = !preloadWr && (wbufCnt != '0);

  assign rdData = (rst && loadAcc) ? (fwdHit ? fwdData : ram[wordIdx]) : RD_ZERO;

  dmem_store_fifo #(
    .IDX_W (DEPTH_LOG2),
    .DEPTH (WBUF_DEPTH)
  ) uFifo (
    .clk       (clk),
    .rst       (rst),
    .push      (storeAcc),
    .pushIdx   (wordIdx),
    .pushData  (wtData),
    .pop       (drain),
    .headIdx   (headIdx),
    .headData  (headData),
    .count     (wbufCnt),
    .lookupIdx (wordIdx),
    .hit       (fwdHit),
    .hitData   (fwdData)
  );

  always_ff @(posedge clk) begin
    if (preloadWr)  ram[ldAddr]  <= ldData;
    else if (drain) ram[headIdx] <= headData;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            alignErr <= 1'b0;
    else if (misaligned) alignErr <= 1'b1;
  end

`ifdef DMEM_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      storeCnt   <= '0;
      loadFwdCnt <= '0;
      ldStallCnt <= '0;
    end else begin
      if (storeAcc)            storeCnt   <= storeCnt + 32'd1;
      if (loadAcc && fwdHit)   loadFwdCnt <= loadFwdCnt + 32'd1;
      if (ldValid && !ldReady) ldStallCnt <= ldStallCnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_data_mem_resp.sv
// Bench for data_mem_resp: table of per-cycle vectors fed through an expectation queue,
// plus a hand-written async-reset sequence.
module tb_data_mem_resp;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        memCe = 1'b0;
  logic        memWr = 1'b0;
  logic [31:0] memAddr = '0;
  logic [31:0] wtData = '0;
  logic [31:0] rdData;
  logic        ldValid = 1'b0;
  logic        ldReady;
  logic [9:0]  ldAddr = '0;
  logic [31:0] ldData = '0;
  logic [2:0]  wbufCnt;
  logic        alignErr;
`ifdef DMEM_STATS_EN
  logic [31:0] storeCnt;
  logic [31:0] loadFwdCnt;
  logic [31:0] ldStallCnt;
`endif

  always #5 clk = ~clk;

  data_mem_resp dut (
    .clk      (clk),
    .rst      (rst),
    .memCe    (memCe),
    .memWr    (memWr),
    .memAddr  (memAddr),
    .wtData   (wtData),
    .rdData   (rdData),
    .ldValid  (ldValid),
    .ldReady  (ldReady),
    .ldAddr   (ldAddr),
    .ldData   (ldData),
    .wbufCnt  (wbufCnt),
    .alignErr (alignErr)
`ifdef DMEM_STATS_EN
    ,
    .storeCnt   (storeCnt),
    .loadFwdCnt (loadFwdCnt),
    .ldStallCnt (ldStallCnt)
`endif
  );

  typedef struct {
    logic        ce;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        ldv;
    logic [9:0]  la;
    logic [31:0] ld;
    logic [31:0] expRd;
    logic [2:0]  expCnt;
    logic        expRdy;
    logic        expErr;
  } vec_t;

  vec_t vecs[$];
  vec_t expQ[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ce, input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input logic v, input logic [9:0] la, input logic [31:0] ld);
    memCe = ce; memWr = wr; memAddr = a; wtData = d;
    ldValid = v; ldAddr = la; ldData = ld;
  endtask

  function automatic vec_t mk(input logic ce, input logic wr, input logic [31:0] a,
                              input logic [31:0] d, input logic v, input logic [9:0] la,
                              input logic [31:0] ld, input logic [31:0] eRd,
                              input logic [2:0] eCnt, input logic eRdy, input logic eErr);
    vec_t r;
    r.ce = ce; r.wr = wr; r.addr = a; r.wdata = d; r.ldv = v; r.la = la; r.ld = ld;
    r.expRd = eRd; r.expCnt = eCnt; r.expRdy = eRdy; r.expErr = eErr;
    return r;
  endfunction

  initial begin
    vec_t e;
    // store then load: forwarded while buffered, then from RAM
    vecs.push_back(mk(1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 32'h0, 0, 1, 0));
    vecs.push_back(mk(1, 0, 32'h10, 0, 0, 0, 0, 32'hDEADBEEF, 1, 1, 0));
    vecs.push_back(mk(1, 0, 32'h10, 0, 0, 0, 0, 32'hDEADBEEF, 0, 1, 0));
    // newest-match forwarding with drain blocked by preloads
    vecs.push_back(mk(1, 1, 32'h20, 32'h1, 1, 100, 32'h111, 32'h0, 0, 1, 0));
    vecs.push_back(mk(1, 1, 32'h20, 32'h2, 1, 100, 32'h111, 32'h0, 1, 1, 0));
    vecs.push_back(mk(1, 0, 32'h20, 0, 1, 100, 32'h111, 32'h2, 2, 1, 0));
    vecs.push_back(mk(1, 0, 32'h20, 0, 0, 0, 0, 32'h2, 2, 1, 0));
    vecs.push_back(mk(1, 0, 32'h20, 0, 0, 0, 0, 32'h2, 1, 1, 0));
    vecs.push_back(mk(1, 0, 32'h20, 0, 0, 0, 0, 32'h2, 0, 1, 0));
    vecs.push_back(mk(1, 0, 32'h190, 0, 0, 0, 0, 32'h111, 0, 1, 0));
    // backpressure: ldReady drops at count 3, count saturates there
    vecs.push_back(mk(1, 1, 32'h40, 32'hA0, 1, 200, 32'h222, 32'h0, 0, 1, 0));
    vecs.push_back(mk(1, 1, 32'h44, 32'hA1, 1, 200, 32'h222, 32'h0, 1, 1, 0));
    vecs.push_back(mk(1, 1, 32'h48, 32'hA2, 1, 200, 32'h222, 32'h0, 2, 1, 0));
    vecs.push_back(mk(1, 1, 32'h4C, 32'hA3, 1, 200, 32'h222, 32'h0, 3, 0, 0));
    vecs.push_back(mk(1, 1, 32'h50, 32'hA4, 1, 200, 32'h222, 32'h0, 3, 0, 0));
    vecs.push_back(mk(0, 0, 32'h0, 0, 1, 200, 32'h222, 32'h0, 3, 0, 0));
    vecs.push_back(mk(1, 0, 32'h40, 0, 1, 200, 32'h222, 32'hA0, 2, 1, 0));
    vecs.push_back(mk(1, 0, 32'h4C, 0, 0, 0, 0, 32'hA3, 2, 1, 0));
    vecs.push_back(mk(1, 0, 32'h50, 0, 0, 0, 0, 32'hA4, 1, 1, 0));
    vecs.push_back(mk(1, 0, 32'h44, 0, 0, 0, 0, 32'hA1, 0, 1, 0));
    vecs.push_back(mk(1, 0, 32'h48, 0, 0, 0, 0, 32'hA2, 0, 1, 0));
    vecs.push_back(mk(1, 0, 32'h50, 0, 0, 0, 0, 32'hA4, 0, 1, 0));
    vecs.push_back(mk(1, 0, 32'h320, 0, 0, 0, 0, 32'h222, 0, 1, 0));
    // misaligned store dropped, misaligned load reads zero, sticky error
    vecs.push_back(mk(1, 1, 32'h13, 32'h5555, 0, 0, 0, 32'h0, 0, 1, 0));
    vecs.push_back(mk(1, 0, 32'h2, 0, 0, 0, 0, 32'h0, 0, 1, 1));
    vecs.push_back(mk(1, 0, 32'h10, 0, 0, 0, 0, 32'hDEADBEEF, 0, 1, 1));
    vecs.push_back(mk(0, 1, 32'h18, 32'h99, 0, 0, 0, 32'h0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 0, 1, 1));
    // aliasing: 0x1014 hits word 5; buffered store overrides later preload
    vecs.push_back(mk(1, 1, 32'h1014, 32'hC0FFEE, 0, 0, 0, 32'h0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 32'h0, 0, 1, 5, 32'hAAAA, 32'h0, 1, 1, 1));
    vecs.push_back(mk(1, 0, 32'h14, 0, 0, 0, 0, 32'hC0FFEE, 1, 1, 1));
    vecs.push_back(mk(1, 0, 32'h14, 0, 0, 0, 0, 32'hC0FFEE, 0, 1, 1));
    vecs.push_back(mk(1, 0, 32'h1014, 0, 0, 0, 0, 32'hC0FFEE, 0, 1, 1));

    // reset state, with a load requested
    drive(1, 0, 32'h10, 0, 1, 0, 0);
    #3;
    chk("reset rdData", rdData, 32'h0);
    chk("reset ldReady", 32'(ldReady), 32'h0);
    chk("reset wbufCnt", 32'(wbufCnt), 32'h0);
    chk("reset alignErr", 32'(alignErr), 32'h0);
    drive(0, 0, 0, 0, 0, 0, 0);
    #9 rst = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk); #1;
      drive(vecs[i].ce, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].ldv, vecs[i].la, vecs[i].ld);
      expQ.push_back(vecs[i]);
      @(negedge clk);
      e = expQ.pop_front();
      chk($sformatf("row%0d rdData", i), rdData, e.expRd);
      chk($sformatf("row%0d wbufCnt", i), 32'(wbufCnt), 32'(e.expCnt));
      chk($sformatf("row%0d ldReady", i), 32'(ldReady), 32'(e.expRdy));
      chk($sformatf("row%0d alignErr", i), 32'(alignErr), 32'(e.expErr));
    end

    // async reset with two stores pending behind blocking preloads
    @(posedge clk); #1; drive(0, 0, 0, 0, 1, 24, 32'h7777);
    @(posedge clk); #1; drive(1, 1, 32'h60, 32'h1111, 1, 300, 32'h333);
    @(posedge clk); #1; drive(1, 1, 32'h64, 32'h2222, 1, 300, 32'h333);
    @(posedge clk); #1; drive(0, 0, 0, 0, 1, 300, 32'h333);
    @(negedge clk);
    chk("pre-reset wbufCnt", 32'(wbufCnt), 32'd2);
`ifdef DMEM_STATS_EN
    chk("storeCnt", storeCnt, 32'd11);
    chk("loadFwdCnt", loadFwdCnt, 32'd7);
    chk("ldStallCnt", ldStallCnt, 32'd3);
`endif
    #2 rst = 1'b0;
    drive(1, 0, 32'h60, 0, 1, 300, 32'h333);
    #1;
    chk("mid reset wbufCnt", 32'(wbufCnt), 32'h0);
    chk("mid reset ldReady", 32'(ldReady), 32'h0);
    chk("mid reset rdData", rdData, 32'h0);
    chk("mid reset alignErr", 32'(alignErr), 32'h0);
`ifdef DMEM_STATS_EN
    chk("reset storeCnt", storeCnt, 32'h0);
    chk("reset loadFwdCnt", loadFwdCnt, 32'h0);
    chk("reset ldStallCnt", ldStallCnt, 32'h0);
`endif
    drive(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1; drive(1, 0, 32'h60, 0, 0, 0, 0);
    @(negedge clk);
    chk("post reset RAM[24]", rdData, 32'h7777);
    chk("post reset wbufCnt", 32'(wbufCnt), 32'h0);
    @(posedge clk); #1; drive(1, 0, 32'h190, 0, 0, 0, 0);
    @(negedge clk);
    chk("post reset RAM[100]", rdData, 32'h111);
    @(posedge clk); #1; drive(0, 0, 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
